// File: rtl/myPkg.sv
// Shared display helpers.
// seg_drv maps a 4-bit hex value onto the 8-bit segment bus.
// Bus layout is {dp, g, f, e, d, c, b, a}, active-high.
// The decimal point is never lit.
package myPkg;

  function automatic logic [7:0] seg_drv(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h07;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h6F;
      4'hA:    s = 8'h77;
      4'hB:    s = 8'h7C;
      4'hC:    s = 8'h39;
      4'hD:    s = 8'h5E;
      4'hE:    s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a NUM_SEG-digit 7-segment display.
//
// Each digit gets a slot made of one guard tick followed by 2**BRIGHT_W drive ticks.
// A tick is DIV clocks long.
// During the drive ticks the digit is lit while sub < bright.
// The digit value and the brightness are captured when the slot's guard starts.
// Because of that capture, a write to the digit being shown never tears the display.
//
// Optional feature macro SEG_BLINK_EN:
//   - adds the blink_mask port and a frame counter;
//   - masked digits go dark for whole frames when fcnt[BLINK_LOG2] is set.
module seg_scan_ctrl #(
  parameter int NUM_SEG    = 6,
  parameter int DIV        = 50000,
  parameter int BRIGHT_W   = 4,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_SEG)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  input  logic [BRIGHT_W-1:0]        bright,
  input  logic                       blank,
`ifdef SEG_BLINK_EN
  input  logic [NUM_SEG-1:0]         blink_mask,
`endif
  output logic [7:0]                 seg,
  output logic [NUM_SEG-1:0]         dig,
  output logic                       frame_done
);

  localparam int AW = $clog2(NUM_SEG);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW-1:0]       IDX_LAST  = AW'(NUM_SEG - 1);
  localparam logic [PW-1:0]       PCNT_LAST = PW'(DIV - 1);
  localparam logic [BRIGHT_W-1:0] SUB_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [BRIGHT_W-1:0]   sub_q, sub_d;
  logic [BRIGHT_W-1:0]   bright_sh_q, bright_sh_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [3:0]            val_sh_q, val_sh_d;
  logic [3:0]            store_q [NUM_SEG];
  logic [3:0]            store_d [NUM_SEG];
  logic [7:0]            seg_q, seg_d;
  logic [NUM_SEG-1:0]    dig_q, dig_d;
  logic                  fd_q, fd_d;
  logic                  tick, slot_end, enter_guard, lit, wr_ok;

`ifdef SEG_BLINK_EN
  logic [BLINK_LOG2:0]   fcnt_q, fcnt_d;
  logic                  dark_q, dark_d;
`else
  // Keeps the blink parameter referenced in builds without blinking.
  wire unused_blink_log2 = (BLINK_LOG2 != 0);
`endif

  assign tick     = (pcnt_q == PCNT_LAST);
  assign slot_end = (state_q == DRIVE) && tick && (sub_q == SUB_LAST);
  assign wr_ok    = wr_en && ({1'b0, wr_addr} < (AW + 1)'(NUM_SEG));

  // Digit store: writes land on the next clock in every state; out-of-range addresses are dropped.
  always_comb begin
    for (int i = 0; i < NUM_SEG; i++) store_d[i] = store_q[i];
    if (wr_ok) store_d[wr_addr] = wr_data;
  end

  // Scan sequencing: prescaler, sub-tick counter, digit index and per-slot shadow capture.
  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    val_sh_d    = val_sh_q;
    bright_sh_d = bright_sh_q;
    fd_d        = 1'b0;
    enter_guard = 1'b0;
    if (blank) begin
      state_d = IDLE;
      pcnt_d  = '0;
      sub_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Index is kept so the scan resumes on the digit it left.
          state_d     = GUARD;
          pcnt_d      = '0;
          enter_guard = 1'b1;
        end
        GUARD: begin
          pcnt_d = tick ? '0 : pcnt_q + 1'b1;
          if (tick) begin
            state_d = DRIVE;
            sub_d   = '0;
          end
        end
        DRIVE: begin
          pcnt_d = tick ? '0 : pcnt_q + 1'b1;
          if (tick) sub_d = sub_q + 1'b1;
          if (slot_end) begin
            state_d     = GUARD;
            enter_guard = 1'b1;
            fd_d        = (idx_q == IDX_LAST);
            idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (enter_guard) begin
      val_sh_d    = store_q[idx_d];
      bright_sh_d = bright;
    end
  end

`ifdef SEG_BLINK_EN
  // Frame counter and per-slot blink decision, fixed at guard entry for the whole slot.
  always_comb begin
    fcnt_d = fd_d ? fcnt_q + 1'b1 : fcnt_q;
    dark_d = enter_guard ? (fcnt_d[BLINK_LOG2] & blink_mask[idx_d]) : dark_q;
  end
  assign lit = (state_d == DRIVE) && (sub_d < bright_sh_d) && !dark_d;
`else
  assign lit = (state_d == DRIVE) && (sub_d < bright_sh_d);
`endif

  // Outputs are computed from next-state values so they line up with the state they describe.
  always_comb begin
    seg_d = lit ? myPkg::seg_drv(val_sh_d) : 8'h00;
    dig_d = lit ? (NUM_SEG'(1) << idx_d) : '0;
  end

  // State, counters, store and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      sub_q       <= '0;
      idx_q       <= '0;
      val_sh_q    <= '0;
      bright_sh_q <= '0;
      for (int i = 0; i < NUM_SEG; i++) store_q[i] <= '0;
      seg_q       <= '0;
      dig_q       <= '0;
      fd_q        <= 1'b0;
`ifdef SEG_BLINK_EN
      fcnt_q      <= '0;
      dark_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      val_sh_q    <= val_sh_d;
      bright_sh_q <= bright_sh_d;
      for (int i = 0; i < NUM_SEG; i++) store_q[i] <= store_d[i];
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      fd_q        <= fd_d;
`ifdef SEG_BLINK_EN
      fcnt_q      <= fcnt_d;
      dark_q      <= dark_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (NUM_SEG=6, DIV=4, BRIGHT_W=2, BLINK_LOG2=1).
// Slot = 20 clocks, frame = 120 clocks.
// Reference model: a slot position counter t (0..19) per digit.
// The digit is lit when t >= DIV and (t-DIV)/DIV < captured brightness.
module tb_seg_scan_ctrl;
  localparam int N    = 6;
  localparam int DIV  = 4;
  localparam int BW   = 2;
  localparam int BL   = 1;
  localparam int SLOT = DIV * (1 + (1 << BW));

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic [BW-1:0] bright = '0;
  logic          blank = 1'b1;
  logic [N-1:0]  blink_mask = '0;
  logic [7:0]    seg;
  logic [N-1:0]  dig;
  logic          frame_done;

  seg_scan_ctrl #(.NUM_SEG(N), .DIV(DIV), .BRIGHT_W(BW), .BLINK_LOG2(BL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bright(bright), .blank(blank),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .dig(dig), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  int         m_store [N];
  int         m_idx, m_t, m_frames, m_sh, m_bsh;
  bit         m_run, m_dark;
  logic [7:0] e_seg;
  logic [N-1:0] e_dig;
  logic       e_fd;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_store[i] = 0;
    m_idx = 0; m_t = 0; m_frames = 0; m_sh = 0; m_bsh = 0;
    m_run = 0; m_dark = 0;
    e_seg = '0; e_dig = '0; e_fd = 1'b0;
  endtask

  task automatic model_latch();
    m_sh  = m_store[m_idx];
    m_bsh = int'(bright);
`ifdef SEG_BLINK_EN
    m_dark = blink_mask[m_idx] && (((m_frames >> BL) & 1) == 1);
`else
    m_dark = 0;
`endif
  endtask

  // Advances the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    bit lit;
    e_fd = 1'b0;
    if (blank) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
      model_latch();
    end else begin
      m_t++;
      if (m_t == SLOT) begin
        m_t = 0;
        m_idx = (m_idx + 1) % N;
        if (m_idx == 0) begin
          e_fd = 1'b1;
          m_frames++;
        end
        model_latch();
      end
    end
    if (wr_en && int'(wr_addr) < N) m_store[wr_addr] = int'(wr_data);
    lit   = m_run && (m_t >= DIV) && (((m_t - DIV) / DIV) < m_bsh) && !m_dark;
    e_dig = lit ? N'(1 << m_idx) : '0;
    e_seg = lit ? seg_tbl[m_sh] : 8'h00;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge clk);
    #1;
    total++;
    if (seg !== 8'h00 || dig !== '0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got seg=%h dig=%b fd=%b want 00 000000 0", seg, dig, frame_done);
    end
    rst = 1'b0;
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL reset_blank cyc=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 cyc, dig, seg, frame_done, e_dig, e_seg, e_fd);
      end
    end
  endtask

  task automatic test_scan_order();
    int last_fd = -1;
    int nfd = 0;
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL scan_write cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
    end
    wr_en = 1'b0;
    bright = 2'd3;
    blank = 1'b0;
    for (int i = 0; i < 2 * N * SLOT + 20; i++) begin
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd || $countones(dig) > 1) begin
        bad++;
        $display("FAIL scan cyc=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 cyc, dig, seg, frame_done, e_dig, e_seg, e_fd);
      end
      if (frame_done === 1'b1) begin
        nfd++;
        if (last_fd >= 0) begin
          total++;
          if (cyc - last_fd != N * SLOT) begin
            bad++;
            $display("FAIL frame_period got %0d want %0d", cyc - last_fd, N * SLOT);
          end
        end
        last_fd = cyc;
      end
    end
    total++;
    if (nfd < 2) begin
      bad++;
      $display("FAIL frame_count got %0d want >=2", nfd);
    end
  endtask

  task automatic test_brightness();
    for (int b = 0; b < 2; b++) begin
      int lit_cnt = 0;
      bright = BW'(b);
      for (int i = 0; i < 2 * N * SLOT; i++) begin
        tick();
        total++;
        if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
          bad++;
          $display("FAIL bright%0d cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", b, cyc, dig, seg, e_dig, e_seg);
        end
        if (i >= N * SLOT && dig !== '0) lit_cnt++;
      end
      total++;
      if (lit_cnt != N * b * DIV) begin
        bad++;
        $display("FAIL bright%0d_duty got %0d lit clks want %0d", b, lit_cnt, N * b * DIV);
      end
    end
  endtask

  task automatic test_no_tear();
    int  waited = 0;
    bit  seen_new = 0;
    bright = 2'd3;
    while (dig !== 6'b000100 && waited < 3 * N * SLOT) begin
      tick();
      waited++;
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL tear_wait cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
    end
    total++;
    if (dig !== 6'b000100) begin
      bad++;
      $display("FAIL tear_timeout got dig=%b want 000100", dig);
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hA;
    tick();
    wr_addr = 3'd6; wr_data = 4'hF;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < N * SLOT + 40; i++) begin
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL tear cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
      if (dig === 6'b000100 && seg === seg_tbl[10]) seen_new = 1;
      tick();
    end
    total++;
    if (!seen_new) begin
      bad++;
      $display("FAIL tear_new_value got seen=0 want seen=1");
    end
  endtask

  task automatic test_blank_resume();
    int waited = 0;
    logic [N-1:0] first_lit = '0;
    while (dig !== 6'b001000 && waited < 2 * N * SLOT) begin
      tick();
      waited++;
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL blank_wait cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
    end
    total++;
    if (dig !== 6'b001000) begin
      bad++;
      $display("FAIL blank_timeout got dig=%b want 001000", dig);
    end
    blank = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL blank_hold cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
    end
    blank = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL resume cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
      if (first_lit == '0 && dig !== '0) first_lit = dig;
    end
    total++;
    if (first_lit !== 6'b001000) begin
      bad++;
      $display("FAIL resume_digit got %b want 001000", first_lit);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      wr_en   = 1'($urandom);
      wr_addr = 3'($urandom);
      wr_data = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bright = BW'($urandom);
      blank   = ($urandom_range(0, 59) == 0);
`ifdef SEG_BLINK_EN
      if ($urandom_range(0, 99) == 0) blink_mask = N'($urandom);
`endif
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL random cyc=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 cyc, dig, seg, frame_done, e_dig, e_seg, e_fd);
      end
    end
    wr_en = 1'b0;
    blank = 1'b0;
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    blink_mask = 6'b000001;
    bright = 2'd3;
    for (int i = 0; i < 6 * N * SLOT; i++) begin
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL blink cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
    end
    blink_mask = '0;
  endtask
`endif

  task automatic test_reset_mid();
    int waited = 0;
    bright = 2'd3;
    blank = 1'b0;
    while (dig === '0 && waited < 2 * N * SLOT) begin
      tick();
      waited++;
    end
    total++;
    if (dig === '0) begin
      bad++;
      $display("FAIL reset_mid_timeout got dig=%b want nonzero", dig);
    end
    rst = 1'b1;
    #1;
    total++;
    if (seg !== 8'h00 || dig !== '0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got seg=%h dig=%b fd=%b want 00 000000 0", seg, dig, frame_done);
    end
    model_reset();
    blank = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL reset_mid_blank cyc=%0d got dig=%b seg=%h fd=%b", cyc, dig, seg, frame_done);
      end
    end
    // Store must be cleared: resuming shows digit 0 with value 0.
    blank = 1'b0;
    for (int i = 0; i < 2 * SLOT; i++) begin
      tick();
      total++;
      if (dig !== e_dig || seg !== e_seg || frame_done !== e_fd) begin
        bad++;
        $display("FAIL reset_mid_resume cyc=%0d got dig=%b seg=%h want dig=%b seg=%h", cyc, dig, seg, e_dig, e_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_brightness();
    test_no_tear();
    test_blank_resume();
    test_random();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
